// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: block-aligned multi-instruction fetch PC generator.
// Issues FETCH_WIDTH-instruction fetch requests with up to MAX_OUTSTANDING
// in flight. Responses that belong to requests issued before a redirect are
// discarded in order, using a drop counter.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds fetch_adel output and
// flags misaligned redirect targets instead of silently aligning them).
module pc_fetch_gen #(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] INIT_PC         = 32'hBFC00000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [31:0]            epc,
    input  logic                   branch_flag,
    input  logic [31:0]            branch_addr,
    input  logic                   ibuffer_full,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    output logic                   resp_valid,
    output logic [31:0]            resp_pc,
    output logic [FETCH_WIDTH-1:0] resp_mask,
`ifdef PC_ALIGN_CHECK_EN
    output logic                   fetch_adel,
`endif
    output logic [31:0]            pc
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0]      BLK_BYTES = 32'(FETCH_WIDTH * 4);
    localparam logic [31:0]      BLK_MASK  = BLK_BYTES - 32'd1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [31:0]            addr;
        logic [FETCH_WIDTH-1:0] mask;
    } fetch_ent_t;

    fetch_ent_t             fifo_q [MAX_OUTSTANDING];
    logic [31:0]            pc_q;
    logic [CNT_W-1:0]       out_cnt;
    logic [CNT_W-1:0]       drop_cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   redirect;
    logic [31:0]            target;
    logic [31:0]            target_ld;
    logic [31:0]            lane_idx;
    logic [FETCH_WIDTH-1:0] req_mask;
    logic                   fetch_block;
    logic                   accept;
    logic                   pop;

    assign redirect = flush || branch_flag;
    assign target   = flush ? epc : branch_addr;

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;
    // A misaligned target is loaded as-is and raises the address-error flag
    // until the next redirect; fetching is stalled meanwhile.
    always_ff @(posedge clk) begin
        if (reset)
            adel_q <= 1'b0;
        else if (redirect)
            adel_q <= (target[1:0] != 2'b00);
    end
    assign fetch_adel  = adel_q;
    assign fetch_block = adel_q;
    assign target_ld   = target;
`else
    assign fetch_block = 1'b0;
    assign target_ld   = target & ~32'h3;
`endif

    assign pc        = pc_q;
    assign inst_addr = pc_q & ~BLK_MASK;
    assign lane_idx  = (pc_q & BLK_MASK) >> 2;

    // Lanes at or above the PC's position within the block are valid.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            req_mask[i] = (32'(i) >= lane_idx);
    end

    assign inst_req   = !reset && !redirect && !ibuffer_full && (out_cnt < MAX_CNT) && !fetch_block;
    assign accept     = inst_req && inst_addr_ok;
    // data_ok with nothing in flight is a bus error and is ignored.
    assign pop        = inst_data_ok && (out_cnt != '0);
    assign resp_valid = pop && (drop_cnt == '0) && !redirect;
    assign resp_pc    = fifo_q[rd_ptr].addr;
    assign resp_mask  = fifo_q[rd_ptr].mask;

    // PC, in-flight count, drop count and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= INIT_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (redirect) begin
                pc_q     <= target_ld;
                // Everything still in flight after this cycle is stale.
                drop_cnt <= out_cnt - CNT_W'(pop);
            end else begin
                if (accept)
                    pc_q <= inst_addr + BLK_BYTES;
                if (pop && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
            end
            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (accept)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Tracking FIFO payload; entries are kept across redirects and drained on data_ok.
    always_ff @(posedge clk) begin
        if (accept)
            fifo_q[wr_ptr] <= '{addr: inst_addr, mask: req_mask};
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: directed scenarios followed by random traffic,
// each cycle compared against a queue-based reference model.
module tb_pc_fetch_gen;

    localparam int          FW   = 2;
    localparam int          MO   = 2;
    localparam logic [31:0] INIT = 32'hBFC00000;
    localparam int          BLK  = FW * 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [31:0]   epc;
    logic          branch_flag;
    logic [31:0]   branch_addr;
    logic          ibuffer_full;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic          resp_valid;
    logic [31:0]   resp_pc;
    logic [FW-1:0] resp_mask;
    logic [31:0]   pc;
`ifdef PC_ALIGN_CHECK_EN
    logic          fetch_adel;
`endif

    pc_fetch_gen #(.FETCH_WIDTH(FW), .MAX_OUTSTANDING(MO), .INIT_PC(INIT)) dut (
        .clk(clk), .reset(reset), .flush(flush), .epc(epc),
        .branch_flag(branch_flag), .branch_addr(branch_addr),
        .ibuffer_full(ibuffer_full), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_mask(resp_mask),
`ifdef PC_ALIGN_CHECK_EN
        .fetch_adel(fetch_adel),
`endif
        .pc(pc)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight request remembers whether it is still live.
    typedef struct {
        logic [31:0]   addr;
        logic [FW-1:0] mask;
        bit            live;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_adel;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [FW-1:0] lanes_from(input logic [31:0] p);
        int lane;
        logic [31:0] all;
        lane = int'((p % BLK) / 4);
        all  = (32'd1 << FW) - 32'd1;
        return FW'((all << lane) & all);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, advance both.
    task automatic step(input bit fl, input logic [31:0] e, input bit br, input logic [31:0] ba,
                        input bit full, input bit aok, input bit dok);
        bit redir, exp_req, popd, exp_rv;
        logic [31:0] tgt;
        ent_t n;
        flush = fl; epc = e; branch_flag = br; branch_addr = ba;
        ibuffer_full = full; inst_addr_ok = aok; inst_data_ok = dok;
        #1;
        redir   = fl || br;
        exp_req = !redir && !full && (mq.size() < MO) && !m_adel;
        popd    = dok && (mq.size() > 0);
        exp_rv  = popd && mq[0].live && !redir;
        chk("pc", pc, m_pc);
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        chk("inst_addr", inst_addr, m_pc - (m_pc % BLK));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
`ifdef PC_ALIGN_CHECK_EN
        chk("fetch_adel", 32'(fetch_adel), 32'(m_adel));
`endif
        if (exp_rv) begin
            chk("resp_pc", resp_pc, mq[0].addr);
            chk("resp_mask", 32'(resp_mask), 32'(mq[0].mask));
        end
        if (popd) void'(mq.pop_front());
        if (redir) begin
            foreach (mq[i]) mq[i].live = 1'b0;
            tgt = fl ? e : ba;
`ifdef PC_ALIGN_CHECK_EN
            m_adel = (tgt % 4) != 0;
            m_pc   = tgt;
`else
            m_pc   = tgt - (tgt % 4);
`endif
        end else if (exp_req && aok) begin
            n.addr = m_pc - (m_pc % BLK);
            n.mask = lanes_from(m_pc);
            n.live = 1'b1;
            mq.push_back(n);
            m_pc = n.addr + BLK;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 0; epc = 0; branch_flag = 0; branch_addr = 0;
        ibuffer_full = 0; inst_addr_ok = 0; inst_data_ok = 0;
        @(posedge clk); #1;
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_pc", pc, INIT);
        reset = 1'b0;
        m_pc = INIT; m_adel = 0; mq.delete();

        // Streaming: accept every cycle, data one cycle later.
        for (int i = 0; i < 6; i++) begin
            if (i < 3) chk("stream_addr", inst_addr, INIT + 32'(8 * i));
            step(0, 0, 0, 0, 0, 1, mq.size() > 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Outstanding limit, then a single response reopens the request.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Branch with two in flight: both stale responses are discarded.
        step(0, 0, 1, 32'hBFC00104, 0, 0, 0);
        chk("br_addr", inst_addr, 32'hBFC00100);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Flush wins over branch in the same cycle.
        step(1, 32'hBFC00380, 1, 32'h80000000, 0, 0, 0);
        chk("flush_prio", pc, 32'hBFC00380);

        // ibuffer_full blocks requests but not in-flight responses.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("full_resume", pc, 32'hBFC00390);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

`ifdef PC_ALIGN_CHECK_EN
        step(1, 32'hBFC00382, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 32'hBFC00400, 0, 1, 0);
        chk("adel_clear_addr", inst_addr, 32'hBFC00400);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
`endif

        // Random traffic, including data_ok with nothing in flight.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
